// File: rtl/rom_dl_arbiter.sv
// HPS ROM download sequencer and single-port ROM arbiter (download writes vs. CPU reads).
// Optional build macro ROM_DL_CHECKSUM_EN enables the running byte checksum on dl_sum.
//
// state  | meaning
// BOOT   | power-up, core held in reset until the first ROM download
// LOAD   | ROM download active, bytes queued into the write FIFO
// SETTLE | download done, FIFO draining then settle timer running
// RUN    | core out of reset, CPU reads served
module rom_dl_arbiter #(
    parameter int          ADDR_W     = 19,
    parameter logic [7:0]  ROM_IDX    = 8'd0,
    parameter logic [7:0]  DIP_IDX    = 8'd254,
    parameter int          SETTLE_CYC = 1024
) (
    input  logic              clk_sys,
    input  logic              reset,
    input  logic              ioctl_download,
    input  logic              ioctl_wr,
    input  logic [7:0]        ioctl_index,
    input  logic [24:0]       ioctl_addr,
    input  logic [7:0]        ioctl_dout,
    output logic              ioctl_wait,
    input  logic              cpu_rd,
    input  logic [ADDR_W-1:0] cpu_addr,
    output logic [7:0]        cpu_rdata,
    output logic              cpu_rvalid,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [7:0]        mem_wdata,
    input  logic              mem_ready,
    input  logic [7:0]        mem_rdata,
    output logic              core_reset,
    output logic [7:0]        dip_sw,
    output logic              dl_err,
    output logic [15:0]       dl_sum
);

    localparam int CNT_W = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;
    localparam logic [CNT_W-1:0] SETTLE_LD = CNT_W'(SETTLE_CYC - 1);

    typedef enum logic [1:0] {BOOT, LOAD, SETTLE, RUN} state_t;
    state_t state, state_nxt;

    logic [1:0]              fifo_cnt;
    logic                    fifo_wr_ptr, fifo_rd_ptr;
    logic [1:0][ADDR_W-1:0]  fifo_addr;
    logic [1:0][7:0]         fifo_data;
    logic [CNT_W-1:0]        settle_cnt;
    logic                    rd_pend;
    logic [ADDR_W-1:0]       rd_addr;

    logic rom_dl, rom_wr, addr_oob, fifo_empty, fifo_full;
    logic push, drop, pop, rd_issue, rd_accept, load_entry, settle_tc;

    assign rom_dl     = ioctl_download && (ioctl_index == ROM_IDX);
    assign rom_wr     = ioctl_wr && (ioctl_index == ROM_IDX) && (state == LOAD);
    assign addr_oob   = (ioctl_addr[24:ADDR_W] != '0);
    assign fifo_empty = (fifo_cnt == 2'd0);
    assign fifo_full  = (fifo_cnt == 2'd2);
    assign push       = rom_wr && !addr_oob && !fifo_full;
    assign drop       = rom_wr && (addr_oob || fifo_full);
    assign pop        = mem_req && mem_we && mem_ready;
    assign rd_issue   = (state == RUN) && rd_pend && fifo_empty;
    assign rd_accept  = rd_issue && mem_ready;
    assign load_entry = (state_nxt == LOAD) && (state != LOAD);
    assign settle_tc  = (settle_cnt == '0);

    assign ioctl_wait = fifo_full;
    assign mem_req    = !fifo_empty || rd_issue;
    assign mem_we     = !fifo_empty;
    assign mem_addr   = fifo_empty ? rd_addr : fifo_addr[fifo_rd_ptr];
    assign mem_wdata  = fifo_empty ? 8'h00 : fifo_data[fifo_rd_ptr];

    always_ff @(posedge clk_sys) begin
        if (reset) state <= BOOT;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt  = state;
        core_reset = 1'b1;
        case (state)
            BOOT:    if (rom_dl) state_nxt = LOAD;
            LOAD:    if (!ioctl_download) state_nxt = SETTLE;
            SETTLE: begin
                if (rom_dl)                        state_nxt = LOAD;
                else if (fifo_empty && settle_tc)  state_nxt = RUN;
            end
            RUN: begin
                core_reset = 1'b0;
                if (rom_dl) state_nxt = LOAD;
            end
            default: state_nxt = BOOT;
        endcase
    end

    // Settle timer holds while the FIFO still has bytes to drain.
    always_ff @(posedge clk_sys) begin
        if (reset || state != SETTLE)        settle_cnt <= SETTLE_LD;
        else if (fifo_empty && !settle_tc)   settle_cnt <= settle_cnt - 1'b1;
    end

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            fifo_cnt    <= 2'd0;
            fifo_wr_ptr <= 1'b0;
            fifo_rd_ptr <= 1'b0;
        end else begin
            if (push) fifo_wr_ptr <= ~fifo_wr_ptr;
            if (pop)  fifo_rd_ptr <= ~fifo_rd_ptr;
            case ({push, pop})
                2'b10:   fifo_cnt <= fifo_cnt + 2'd1;
                2'b01:   fifo_cnt <= fifo_cnt - 2'd1;
                default: fifo_cnt <= fifo_cnt;
            endcase
        end
    end

    always_ff @(posedge clk_sys) begin
        if (push) begin
            fifo_addr[fifo_wr_ptr] <= ioctl_addr[ADDR_W-1:0];
            fifo_data[fifo_wr_ptr] <= ioctl_dout;
        end
    end

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            rd_pend    <= 1'b0;
            rd_addr    <= '0;
            cpu_rvalid <= 1'b0;
            cpu_rdata  <= 8'h00;
        end else begin
            cpu_rvalid <= rd_accept;
            if (rd_accept) cpu_rdata <= mem_rdata;
            // Leaving RUN only ever goes to LOAD, which abandons the pending read.
            if (state != RUN)               rd_pend <= 1'b0;
            else if (rd_accept)             rd_pend <= 1'b0;
            else if (cpu_rd && !rd_pend) begin
                rd_pend <= 1'b1;
                rd_addr <= cpu_addr;
            end
        end
    end

    always_ff @(posedge clk_sys) begin
        if (reset || load_entry) dl_err <= 1'b0;
        else if (drop)           dl_err <= 1'b1;
    end

    // Only DIP byte 0 reaches an output, so bytes 1..7 are accepted but not stored.
    always_ff @(posedge clk_sys) begin
        if (reset)
            dip_sw <= 8'h00;
        else if (ioctl_wr && ioctl_index == DIP_IDX && ioctl_addr == 25'd0)
            dip_sw <= ioctl_dout;
    end

`ifdef ROM_DL_CHECKSUM_EN
    always_ff @(posedge clk_sys) begin
        if (reset || load_entry) dl_sum <= 16'h0000;
        else if (push)           dl_sum <= dl_sum + {8'h00, ioctl_dout};
    end
`else
    assign dl_sum = 16'h0000;
`endif

endmodule

// File: tb/tb_rom_dl_arbiter.sv
// Randomized self-checking bench for rom_dl_arbiter against a queue-based write/read model.
module tb_rom_dl_arbiter;
    localparam int ADDR_W = 19;
    localparam int SETTLE = 8;

    logic              clk_sys = 1'b0;
    logic              reset;
    logic              ioctl_download, ioctl_wr, ioctl_wait;
    logic [7:0]        ioctl_index, ioctl_dout;
    logic [24:0]       ioctl_addr;
    logic              cpu_rd, cpu_rvalid;
    logic [ADDR_W-1:0] cpu_addr;
    logic [7:0]        cpu_rdata;
    logic              mem_req, mem_we, mem_ready;
    logic [ADDR_W-1:0] mem_addr;
    logic [7:0]        mem_wdata, mem_rdata;
    logic              core_reset, dl_err;
    logic [7:0]        dip_sw;
    logic [15:0]       dl_sum;

    rom_dl_arbiter #(.ADDR_W(ADDR_W), .ROM_IDX(8'd0), .DIP_IDX(8'd254), .SETTLE_CYC(SETTLE)) dut (
        .clk_sys(clk_sys), .reset(reset),
        .ioctl_download(ioctl_download), .ioctl_wr(ioctl_wr), .ioctl_index(ioctl_index),
        .ioctl_addr(ioctl_addr), .ioctl_dout(ioctl_dout), .ioctl_wait(ioctl_wait),
        .cpu_rd(cpu_rd), .cpu_addr(cpu_addr), .cpu_rdata(cpu_rdata), .cpu_rvalid(cpu_rvalid),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_ready(mem_ready), .mem_rdata(mem_rdata),
        .core_reset(core_reset), .dip_sw(dip_sw), .dl_err(dl_err), .dl_sum(dl_sum)
    );

    always #5 clk_sys = ~clk_sys;

    int          n_checks = 0;
    int          n_fail   = 0;
    int          rvalid_cnt = 0;
    bit          chk_stable = 1'b0;
    bit          prev_stall = 1'b0;
    logic [28:0] prev_bus = '0;
    logic [15:0] model_sum = 16'h0;
    logic [26:0] exp_wr[$];
    logic [26:0] got_wr[$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Bus observer: completed writes, read strobes, request stability under stall.
    always @(negedge clk_sys) begin
        if (mem_req && mem_we && mem_ready) got_wr.push_back({mem_addr, mem_wdata});
        if (cpu_rvalid) rvalid_cnt++;
        if (chk_stable && prev_stall)
            check("mem_stable", {3'b0, mem_req, mem_we, mem_addr, mem_wdata}, {3'b0, prev_bus});
        prev_stall = mem_req && !mem_ready;
        prev_bus   = {mem_req, mem_we, mem_addr, mem_wdata};
    end

    initial begin
        #500000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk_sys);
        #1;
    endtask

    task automatic start_load();
        ioctl_index    = 8'd0;
        ioctl_download = 1'b1;
        model_sum      = 16'h0;
        tick();
        check("load_core_reset", core_reset, 1);
        check("load_err_clear", dl_err, 0);
    endtask

    task automatic send_raw(input logic [24:0] a, input logic [7:0] d);
        ioctl_wr = 1'b1; ioctl_addr = a; ioctl_dout = d;
        tick();
        ioctl_wr = 1'b0;
    endtask

    task automatic send_rom(input logic [24:0] a, input logic [7:0] d);
        exp_wr.push_back({a[ADDR_W-1:0], d});
        model_sum = model_sum + {8'h00, d};
        send_raw(a, d);
    endtask

    task automatic finish_load(input bit exact);
        int k;
        ioctl_download = 1'b0;
        tick();
        k = 0;
        while (core_reset && k < 64) begin
            tick();
            k++;
        end
        if (exact) check("release_cycles", k, SETTLE);
        else       check("released", core_reset, 0);
    endtask

    task automatic compare_writes(input string tag);
        check({tag, "_count"}, got_wr.size(), exp_wr.size());
        for (int i = 0; i < exp_wr.size() && i < got_wr.size(); i++)
            check(tag, {5'b0, got_wr[i]}, {5'b0, exp_wr[i]});
        got_wr.delete();
        exp_wr.delete();
    endtask

    task automatic check_sum(input string tag);
`ifdef ROM_DL_CHECKSUM_EN
        check(tag, dl_sum, model_sum);
`else
        check(tag, dl_sum, 0);
`endif
    endtask

    initial begin
        logic [24:0] a;
        logic [7:0]  d;
        int n, cnt, stall, saved;

        reset = 1'b1; ioctl_download = 0; ioctl_wr = 0; ioctl_index = 0;
        ioctl_addr = 0; ioctl_dout = 0; cpu_rd = 0; cpu_addr = 0;
        mem_ready = 0; mem_rdata = 0;
        repeat (3) tick();
        check("rst_core_reset", core_reset, 1);
        check("rst_wait", ioctl_wait, 0);
        check("rst_mem_req", mem_req, 0);
        check("rst_mem_we", mem_we, 0);
        check("rst_rvalid", cpu_rvalid, 0);
        check("rst_rdata", cpu_rdata, 0);
        check("rst_dip", dip_sw, 0);
        check("rst_err", dl_err, 0);
        check("rst_sum", dl_sum, 0);
        reset = 1'b0;
        repeat (3) tick();
        check("boot_hold", core_reset, 1);

        // Directed 4-byte load with a free memory port
        mem_ready = 1'b1;
        start_load();
        check("idle_mem_req", mem_req, 0);
        send_rom(25'd0, 8'h11);
        check("first_req", {mem_req, mem_we}, 2'b11);
        check("first_bus", {5'b0, mem_addr, mem_wdata}, {5'b0, 19'd0, 8'h11});
        send_rom(25'd1, 8'h22);
        check("wait_low1", ioctl_wait, 0);
        send_rom(25'd2, 8'h33);
        check("wait_low2", ioctl_wait, 0);
        send_rom(25'd3, 8'h44);
        check("wait_low3", ioctl_wait, 0);
        repeat (2) tick();
        finish_load(1);
        compare_writes("wr_directed");
        check_sum("sum_directed");
        check("err_directed", dl_err, 0);

        // Random addresses and gaps, memory always ready
        start_load();
        n = $urandom_range(6, 16);
        for (int i = 0; i < n; i++) begin
            a = 25'($urandom_range(0, (1 << ADDR_W) - 1));
            d = 8'($urandom);
            send_rom(a, d);
            check("wait_never", ioctl_wait, 0);
            repeat ($urandom_range(0, 2)) tick();
        end
        repeat (2) tick();
        finish_load(1);
        compare_writes("wr_rand_gap");
        check_sum("sum_rand_gap");

        // Random memory readiness, HPS honours ioctl_wait
        chk_stable = 1'b1;
        start_load();
        n = $urandom_range(10, 24);
        cnt = 0;
        for (int c = 0; c < 2000 && cnt < n; c++) begin
            mem_ready = 1'($urandom_range(0, 1));
            if (!ioctl_wait && $urandom_range(0, 3) != 0) begin
                a = 25'($urandom_range(0, (1 << ADDR_W) - 1));
                d = 8'($urandom);
                exp_wr.push_back({a[ADDR_W-1:0], d});
                model_sum = model_sum + {8'h00, d};
                ioctl_wr = 1'b1; ioctl_addr = a; ioctl_dout = d;
                cnt++;
            end else begin
                ioctl_wr = 1'b0;
            end
            tick();
        end
        ioctl_wr = 1'b0;
        mem_ready = 1'b1;
        repeat (4) tick();
        finish_load(1);
        compare_writes("wr_rand_ready");
        check_sum("sum_rand_ready");
        check("err_rand_ready", dl_err, 0);
        chk_stable = 1'b0;

        // Backpressure: two pushes fill the FIFO, third strobe dropped
        start_load();
        mem_ready = 1'b0;
        send_rom(25'h10, 8'($urandom));
        check("bp_wait_1", ioctl_wait, 0);
        send_rom(25'h11, 8'($urandom));
        check("bp_wait_2", ioctl_wait, 1);
        send_raw(25'h12, 8'($urandom));
        check("bp_err", dl_err, 1);
        check("bp_wait_3", ioctl_wait, 1);
        mem_ready = 1'b1;
        repeat (4) tick();
        check("bp_wait_drained", ioctl_wait, 0);
        compare_writes("wr_bp");
        check_sum("sum_bp");
        finish_load(1);
        check("bp_err_sticky", dl_err, 1);

        // CPU reads in RUN with random stall
        chk_stable = 1'b1;
        for (int r = 0; r < 5; r++) begin
            a = (r == 0) ? 25'd2 : 25'($urandom_range(0, (1 << ADDR_W) - 1));
            d = (r == 0) ? 8'h5A : 8'($urandom);
            stall = (r == 0) ? 0 : $urandom_range(0, 3);
            cpu_addr = a[ADDR_W-1:0]; cpu_rd = 1'b1; mem_rdata = d; mem_ready = 1'b0;
            tick();
            check("rd_req", {mem_req, mem_we}, 2'b10);
            check("rd_addr", mem_addr, a[ADDR_W-1:0]);
            cpu_addr = ~a[ADDR_W-1:0];
            n = 1;
            while (!cpu_rvalid && n < 20) begin
                mem_ready = (n > stall);
                tick();
                cpu_rd = 1'b0;
                n++;
            end
            check("rd_latency", n, stall + 2);
            check("rd_data", cpu_rdata, d);
            check("rd_second_ignored", mem_req, 0);
            tick();
            check("rd_pulse", cpu_rvalid, 0);
        end
        check("rd_count", rvalid_cnt, 5);
        chk_stable = 1'b0;

        // DIP bytes in RUN
        ioctl_download = 1'b1; ioctl_index = 8'd254;
        send_raw(25'd0, 8'h80);
        check("dip_0", dip_sw, 8'h80);
        check("dip_core_run", core_reset, 0);
        send_raw(25'd8, 8'h3C);
        check("dip_addr8", dip_sw, 8'h80);
        send_raw(25'd1, 8'h3C);
        check("dip_addr1", dip_sw, 8'h80);
        d = 8'($urandom_range(1, 255));
        send_raw(25'd0, d);
        check("dip_rand", dip_sw, d);
        check("dip_no_write", got_wr.size(), 0);
        ioctl_download = 1'b0; ioctl_index = 8'd0;
        tick();
        check("dip_core_after", core_reset, 0);

        // Re-download with a read pending
        mem_ready = 1'b0;
        cpu_addr = 19'h1234; cpu_rd = 1'b1;
        tick();
        cpu_rd = 1'b0;
        tick();
        check("redl_pending", mem_req, 1);
        saved = rvalid_cnt;
        ioctl_index = 8'd0; ioctl_download = 1'b1; model_sum = 16'h0;
        tick();
        check("redl_core_reset", core_reset, 1);
        check("redl_req_drop", mem_req, 0);
        mem_ready = 1'b1;
        repeat (3) tick();
        check("redl_no_rvalid", rvalid_cnt, saved);
        send_rom(25'h7FFFF, 8'($urandom));
        send_rom(25'h00005, 8'($urandom));
        repeat (2) tick();
        finish_load(1);
        compare_writes("wr_redl");
        check_sum("sum_redl");
        check("redl_no_rvalid_end", rvalid_cnt, saved);

        // Out-of-range byte dropped
        start_load();
        send_raw(25'h80000, 8'($urandom));
        check("oob_no_req", mem_req, 0);
        check("oob_err", dl_err, 1);
        tick();
        check("oob_no_req2", mem_req, 0);
        send_rom(25'h00042, 8'($urandom));
        repeat (2) tick();
        finish_load(1);
        compare_writes("wr_oob");
        check_sum("sum_oob");

        // Reset while a write is stalled
        start_load();
        mem_ready = 1'b0;
        send_raw(25'h00100, 8'($urandom));
        check("mid_req", mem_req, 1);
        reset = 1'b1;
        tick();
        check("mid_req_drop", mem_req, 0);
        check("mid_core_reset", core_reset, 1);
        check("mid_dip", dip_sw, 0);
        reset = 1'b0; ioctl_download = 1'b0; mem_ready = 1'b1;
        repeat (3) tick();
        check("mid_flushed", mem_req, 0);
        check("mid_boot", core_reset, 1);
        check("mid_sum", dl_sum, 0);
        compare_writes("wr_mid");

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
